// File: rtl/pc_pkg.sv
// pc_pkg: shared types and helpers for the fetch-stage program-counter unit.
//   next_sel_t     - which source feeds the PC register on the next edge
//   INSTR_SHIFT_DEF - default log2 of the instruction size in bytes
//   sext_scale()   - sign-extends a raw word offset and converts it to bytes
package pc_pkg;

   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_BR,
      SEL_RET,
      SEL_REDIR,
      SEL_HOLD
   } next_sel_t;

   localparam int INSTR_SHIFT_DEF = 2;

   // Widest PC supported by sext_scale; callers truncate to their own width,
   // which keeps the sum modulo 2^WIDTH.
   localparam int MAX_W = 128;

   // Offsets arrive as 26-bit signed words; the 19-bit conditional field is
   // sign-extended to 26 bits by the caller before it gets here.
   function automatic logic [MAX_W-1:0] sext_scale(input logic signed [25:0] off,
                                                  input int unsigned       shift);
      logic signed [MAX_W-1:0] ext;
      ext = {{(MAX_W-26){off[25]}}, off};
      return ext <<< shift;
   endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: control and status bundle of the program-counter unit.
//   master - driven by control / branch-resolution logic (owns the requests)
//   slave  - the pc_gen side (owns pc, pc_plus4 and the RAS status)
// Signals:
//   stall, redirect_valid, redirect_pc       flow control and flush
//   br_taken, uncond_br, cond_addr19, br_addr26, link   branch request
//   ret, ret_reg_addr                        return request and fallback target
//   pc, pc_plus4, ras_count, ras_overflow    outputs
interface pc_gen_if #(
   parameter int WIDTH     = 64,
   parameter int RAS_DEPTH = 4
);
   localparam int CW = $clog2(RAS_DEPTH) + 1;

   logic                 stall;
   logic                 redirect_valid;
   logic [WIDTH-1:0]     redirect_pc;
   logic                 br_taken;
   logic                 uncond_br;
   logic signed [18:0]   cond_addr19;
   logic signed [25:0]   br_addr26;
   logic                 link;
   logic                 ret;
   logic [WIDTH-1:0]     ret_reg_addr;
   logic [WIDTH-1:0]     pc;
   logic [WIDTH-1:0]     pc_plus4;
   logic [CW-1:0]        ras_count;
   logic                 ras_overflow;

   modport master (
      output stall, redirect_valid, redirect_pc, br_taken, uncond_br,
             cond_addr19, br_addr26, link, ret, ret_reg_addr,
      input  pc, pc_plus4, ras_count, ras_overflow
   );

   modport slave (
      input  stall, redirect_valid, redirect_pc, br_taken, uncond_br,
             cond_addr19, br_addr26, link, ret, ret_reg_addr,
      output pc, pc_plus4, ras_count, ras_overflow
   );
endinterface

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
//   clk, reset_n  rising-edge clock, synchronous active-low reset
//   push          write push_data at ptr, then advance ptr
//   pop           step ptr back (only when count is non-zero)
//   push_data     return address to store
//   top           entry just below ptr (meaningful only while count > 0)
//   count         number of valid entries, saturates at RAS_DEPTH
//   overflow      sticky; set when a push lands on a still-valid entry
module ras_stack #(
   parameter int WIDTH     = 64,
   parameter int RAS_DEPTH = 4,
   localparam int PW       = $clog2(RAS_DEPTH),
   localparam int CW       = PW + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count,
   output logic             overflow
);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] FULL    = CW'(RAS_DEPTH);

   logic [WIDTH-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    top_idx;
   logic [CW-1:0]    cnt;
   logic             ovf;

   // ptr always names the next free slot; when full it also names the
   // oldest entry, so a push there naturally evicts the oldest address.
   assign top_idx  = ptr - PTR_ONE;
   assign top      = mem[top_idx];
   assign count    = cnt;
   assign overflow = ovf;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (pop) begin
         if (cnt != '0) begin
            ptr <= ptr - PTR_ONE;
            cnt <= cnt - CNT_ONE;
         end
      end else if (push) begin
         ptr <= ptr + PTR_ONE;
         if (cnt == FULL) ovf <= 1'b1;
         else             cnt <= cnt + CNT_ONE;
      end
   end

   // Entry storage carries no reset; count gates whether top is ever used.
   always_ff @(posedge clk) begin
      if (reset_n && push && !pop) mem[ptr] <= push_data;
   end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter unit.
//   clk, reset_n  rising-edge clock, synchronous active-low reset
//   bus (slave)   requests: stall, redirect, branch (conditional/unconditional,
//                 optional link), return with fallback target;
//                 outputs: pc (registered), pc_plus4 (combinational),
//                 ras_count, ras_overflow
// Next-PC priority: reset > redirect > stall > ret > taken branch > sequential.
module pc_gen
   import pc_pkg::*;
#(
   parameter int               WIDTH       = 64,
   parameter int               RAS_DEPTH   = 4,
   parameter logic [WIDTH-1:0] RESET_PC    = '0,
   parameter int               INSTR_SHIFT = INSTR_SHIFT_DEF
) (
   input logic     clk,
   input logic     reset_n,
   pc_gen_if.slave bus
);
   localparam logic [WIDTH-1:0] INSTR_BYTES = WIDTH'(1) << INSTR_SHIFT;
   // Clears the sub-instruction byte bits of externally supplied targets.
   localparam logic [WIDTH-1:0] ALIGN_MASK  = {WIDTH{1'b1}} << INSTR_SHIFT;

   logic [WIDTH-1:0]   pc_r;
   logic [WIDTH-1:0]   seq_pc;
   logic [WIDTH-1:0]   br_target;
   logic [WIDTH-1:0]   next_pc;
   logic signed [25:0] raw_off;
   next_sel_t          sel;
   logic               push;
   logic               pop;
   logic [WIDTH-1:0]   ras_top;

   assign seq_pc       = pc_r + INSTR_BYTES;
   assign bus.pc       = pc_r;
   assign bus.pc_plus4 = seq_pc;

   always_comb begin
      raw_off   = bus.uncond_br ? bus.br_addr26
                                : {{7{bus.cond_addr19[18]}}, bus.cond_addr19};
      br_target = pc_r + WIDTH'(sext_scale(raw_off, INSTR_SHIFT));
   end

   always_comb begin
      sel = SEL_SEQ;
      if (bus.redirect_valid)  sel = SEL_REDIR;
      else if (bus.stall)      sel = SEL_HOLD;
      else if (bus.ret)        sel = SEL_RET;
      else if (bus.br_taken)   sel = SEL_BR;
   end

   // link only matters on a taken branch; ret already outranks it in sel.
   assign push = (sel == SEL_BR) && bus.link;
   assign pop  = (sel == SEL_RET);

   always_comb begin
      next_pc = seq_pc;
      case (sel)
         SEL_REDIR: next_pc = bus.redirect_pc & ALIGN_MASK;
         SEL_HOLD:  next_pc = pc_r;
         SEL_RET:   next_pc = ((bus.ras_count != '0) ? ras_top : bus.ret_reg_addr)
                              & ALIGN_MASK;
         SEL_BR:    next_pc = br_target;
         default:   next_pc = seq_pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) pc_r <= RESET_PC;
      else          pc_r <= next_pc;
   end

   ras_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (pop),
      .push_data (seq_pc),
      .top       (ras_top),
      .count     (bus.ras_count),
      .overflow  (bus.ras_overflow)
   );
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen with a queue-based reference model
// checked every cycle plus hand-computed literal expectations.
module tb_pc_gen;
   localparam int WIDTH = 64;
   localparam int DEPTH = 4;

   logic clk;
   logic reset_n;
   int   total;
   int   bad;

   pc_gen_if #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) bus ();

   pc_gen #(
      .WIDTH       (WIDTH),
      .RAS_DEPTH   (DEPTH),
      .RESET_PC    (64'h0),
      .INSTR_SHIFT (2)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   longint unsigned m_pc;
   longint unsigned m_ras[$];
   bit              m_ovf;
   bit              m_valid;

   initial begin
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_pc    = 0;
   end

   always @(posedge clk) begin
      longint signed   off;
      longint unsigned tgt;
      if (!reset_n) begin
         m_pc = 0;
         m_ras.delete();
         m_ovf = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (bus.redirect_valid) begin
            m_pc = bus.redirect_pc & ~64'h3;
         end else if (bus.stall) begin
            m_pc = m_pc;
         end else if (bus.ret) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back() & ~64'h3;
            else                  m_pc = bus.ret_reg_addr & ~64'h3;
         end else if (bus.br_taken) begin
            if (bus.uncond_br) off = longint'(bus.br_addr26);
            else               off = longint'(bus.cond_addr19);
            tgt = m_pc + longint'(off * 4);
            if (bus.link) begin
               m_ras.push_back(m_pc + 4);
               if (m_ras.size() > DEPTH) begin
                  void'(m_ras.pop_front());
                  m_ovf = 1'b1;
               end
            end
            m_pc = tgt;
         end else begin
            m_pc = m_pc + 4;
         end
      end
      #1;
      if (m_valid) begin
         total++;
         if (bus.pc !== m_pc) begin
            bad++;
            $display("FAIL model_pc: got %h want %h", bus.pc, m_pc);
         end
         total++;
         if (bus.pc_plus4 !== m_pc + 64'd4) begin
            bad++;
            $display("FAIL model_pc_plus4: got %h want %h", bus.pc_plus4, m_pc + 64'd4);
         end
         total++;
         if (bus.ras_count !== 3'(m_ras.size())) begin
            bad++;
            $display("FAIL model_ras_count: got %0d want %0d", bus.ras_count, m_ras.size());
         end
         total++;
         if (bus.ras_overflow !== m_ovf) begin
            bad++;
            $display("FAIL model_ras_overflow: got %0b want %0b", bus.ras_overflow, m_ovf);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic idle_in();
      bus.stall          = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.br_taken       = 1'b0;
      bus.uncond_br      = 1'b0;
      bus.cond_addr19    = '0;
      bus.br_addr26      = '0;
      bus.link           = 1'b0;
      bus.ret            = 1'b0;
      bus.ret_reg_addr   = '0;
   endtask

   // One clock edge; inputs change and literals are checked 2 units after it.
   task automatic cyc();
      @(posedge clk);
      #2;
      idle_in();
   endtask

   task automatic redir(input logic [63:0] a);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = a;
      cyc();
   endtask

   task automatic bl(input logic signed [25:0] off);
      bus.br_taken  = 1'b1;
      bus.uncond_br = 1'b1;
      bus.link      = 1'b1;
      bus.br_addr26 = off;
      cyc();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      idle_in();
      reset_n = 1'b1;
      #2;

      // 1. reset, then free-run
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      chk("reset_pc", bus.pc, 64'h0);
      chk("reset_cnt", 64'(bus.ras_count), 64'd0);
      chk("reset_ovf", 64'(bus.ras_overflow), 64'd0);
      cyc(); chk("seq1", bus.pc, 64'h4);
      cyc(); chk("seq2", bus.pc, 64'h8);
      cyc(); chk("seq3", bus.pc, 64'hC);
      chk("pc_plus4", bus.pc_plus4, 64'h10);

      // 2. offsets
      redir(64'h100);
      chk("redir_100", bus.pc, 64'h100);
      bus.br_taken = 1'b1; bus.cond_addr19 = 19'h7FFFE;
      cyc(); chk("cond_neg", bus.pc, 64'hF8);
      bus.br_taken = 1'b1; bus.uncond_br = 1'b1; bus.br_addr26 = 26'd3;
      cyc(); chk("uncond_pos", bus.pc, 64'h104);
      redir(64'h0);
      bus.br_taken = 1'b1; bus.uncond_br = 1'b1; bus.br_addr26 = 26'h3FFFFFF;
      cyc(); chk("wrap_neg", bus.pc, 64'hFFFF_FFFF_FFFF_FFFC);
      bus.br_taken = 1'b1; bus.cond_addr19 = 19'd1;
      cyc(); chk("wrap_pos", bus.pc, 64'h0);

      // 3. call / return
      redir(64'h200);
      bl(26'h40);
      chk("call_pc", bus.pc, 64'h300);
      chk("call_cnt", 64'(bus.ras_count), 64'd1);
      bus.ret = 1'b1; bus.ret_reg_addr = 64'h999;
      cyc(); chk("ret_pc", bus.pc, 64'h204);
      chk("ret_cnt", 64'(bus.ras_count), 64'd0);

      // link without taken branch: no push
      bus.link = 1'b1;
      cyc(); chk("link_only_cnt", 64'(bus.ras_count), 64'd0);

      // 4. overflow / underflow
      redir(64'h400);
      for (int i = 0; i < 5; i++) bl(26'd1);
      chk("ovf_pc", bus.pc, 64'h414);
      chk("ovf_cnt", 64'(bus.ras_count), 64'd4);
      chk("ovf_flag", 64'(bus.ras_overflow), 64'd1);
      for (int i = 0; i < 4; i++) begin
         bus.ret = 1'b1; bus.ret_reg_addr = 64'h777;
         cyc();
         chk("pop_pc", bus.pc, 64'h414 - 64'(4 * i));
      end
      bus.ret = 1'b1; bus.ret_reg_addr = 64'h777;
      cyc(); chk("fallback_pc", bus.pc, 64'h774);
      chk("fallback_cnt", 64'(bus.ras_count), 64'd0);

      // 5. stall vs redirect
      bl(26'd2);
      chk("pre_stall_pc", bus.pc, 64'h77C);
      bus.stall = 1'b1; bus.br_taken = 1'b1; bus.uncond_br = 1'b1;
      bus.link = 1'b1; bus.br_addr26 = 26'd5;
      cyc(); chk("stall_pc", bus.pc, 64'h77C);
      chk("stall_cnt", 64'(bus.ras_count), 64'd1);
      bus.stall = 1'b1; bus.ret = 1'b1;
      cyc(); chk("stall_ret_cnt", 64'(bus.ras_count), 64'd1);
      bus.stall = 1'b1;
      redir(64'h1002);
      chk("stall_redir", bus.pc, 64'h1000);
      chk("redir_cnt", 64'(bus.ras_count), 64'd1);

      // ret + link together: ret wins, pops, no push
      bus.ret = 1'b1; bus.link = 1'b1; bus.br_taken = 1'b1; bus.uncond_br = 1'b1;
      bus.br_addr26 = 26'd8;
      cyc(); chk("ret_link_pc", bus.pc, 64'h778);
      chk("ret_link_cnt", 64'(bus.ras_count), 64'd0);

      // 6. reset mid-operation
      for (int i = 0; i < 3; i++) bl(26'd4);
      chk("mid_cnt", 64'(bus.ras_count), 64'd3);
      chk("mid_ovf_sticky", 64'(bus.ras_overflow), 64'd1);
      reset_n = 1'b0; bus.ret = 1'b1;
      cyc();
      reset_n = 1'b1;
      chk("mid_reset_pc", bus.pc, 64'h0);
      chk("mid_reset_cnt", 64'(bus.ras_count), 64'd0);
      chk("mid_reset_ovf", 64'(bus.ras_overflow), 64'd0);
      cyc(); chk("post_reset_seq", bus.pc, 64'h4);

      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter unit for the fetch stage. Holds the PC register and computes the sequential and PC-relative branch targets from raw offset fields, with sign-extension and scaling done internally.
- Adds stall, external redirect (pipeline flush) and a circular return-address stack (RAS) that predicts function returns.
- Feeds instruction memory directly; control and branch-resolution logic drive its inputs.

Parameters:
- WIDTH, 64, PC/address width in bits.
- RAS_DEPTH, 4, return-address stack entries (power of 2, at least 2).
- RESET_PC, 0, PC value loaded on reset.
- INSTR_SHIFT, 2, log2 of instruction size in bytes; offsets are shifted left by this amount.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- stall  in  1  hold the PC and the RAS this cycle.
- redirect_valid  in  1  flush; load redirect_pc.
- redirect_pc  in  WIDTH  flush target.
- br_taken  in  1  a branch is taken this cycle.
- uncond_br  in  1  1: use br_addr26; 0: use cond_addr19.
- cond_addr19  in  19  signed word offset for conditional branches.
- br_addr26  in  26  signed word offset for unconditional branches.
- link  in  1  branch-with-link; push pc+instr size onto the RAS.
- ret  in  1  return; pop the RAS.
- ret_reg_addr  in  WIDTH  fallback return target, used when the RAS is empty.
- pc  out  WIDTH  current PC (registered).
- pc_plus4  out  WIDTH  pc + (1<<INSTR_SHIFT), combinational.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_overflow  out  1  sticky; set when a push overwrites a valid entry.

Behaviour:
- Reset: on a clk edge with reset_n=0, set pc=RESET_PC, ras_count=0, ras_overflow=0 and the RAS pointer to 0. Reset overrides every other input, including mid-operation.
- Arithmetic:
  - offset = sign-extend to WIDTH, then shift left by INSTR_SHIFT.
  - Branch target = pc + offset.
  - All sums are modulo 2^WIDTH (wrap silently, no flags).
  - The low INSTR_SHIFT bits of redirect_pc and of the popped or fallback return address are forced to 0.
- Next-PC priority, one update per edge:
  1. reset.
  2. redirect_valid: pc<=redirect_pc; RAS unchanged.
  3. stall: pc held; RAS unchanged; link and ret are ignored.
  4. ret: pc<=RAS top if ras_count>0, else ret_reg_addr. Pop only when not empty.
  5. br_taken: pc<=branch target. If link=1, push pc_plus4.
  6. otherwise: pc<=pc_plus4.
- Latency: the new pc is visible one cycle after the inputs are sampled.
- link without br_taken: no push (BL is always a taken branch).
- ret and link asserted together: ret wins; no push.
- RAS storage:
  - Circular buffer: push writes at ptr then increments ptr; pop decrements ptr then reads.
  - Push when ras_count==RAS_DEPTH: the oldest entry is overwritten, ras_count stays at RAS_DEPTH, ras_overflow is set.
  - Pop when ras_count==0: fallback target is used; count stays 0; no underflow flag.
  - Pointer wraps modulo RAS_DEPTH.
- ras_overflow clears only on reset.
- No X propagation: the contents of unused RAS entries never reach pc.

Decomposition:
- Package pc_pkg holds:
  - enum next_sel_t {SEL_SEQ, SEL_BR, SEL_RET, SEL_REDIR, SEL_HOLD};
  - the sign-extend/scale function;
  - the default INSTR_SHIFT constant.
- Sub-module ras_stack (WIDTH, RAS_DEPTH) contains the circular buffer, pointer, count and overflow flag.
  - Interface: push, pop, push_data, top, count, overflow.
- pc_gen contains the priority select and the pc register.

Test Plan:
1. Reset then free-run: hold reset_n=0 for one edge -> pc=0, ras_count=0. Then 3 idle cycles -> pc=0x4, 0x8, 0xC.
2. Offsets:
   - pc=0x100, br_taken=1, uncond_br=0, cond_addr19=19'h7FFFE -> pc=0xF8.
   - Next: uncond_br=1, br_addr26=3 -> pc=0x104.
   - pc=0x0 with offset -1 -> pc=0xFFFF_FFFF_FFFF_FFFC (wrap).
3. Call/return: pc=0x200, br_taken=1, uncond_br=1, link=1, br_addr26=0x40 -> pc=0x300, ras_count=1. Next ret=1 -> pc=0x204, ras_count=0.
4. Overflow/underflow (depth 4):
   - 5 BLs push A1..A5 -> ras_count=4, ras_overflow=1.
   - 4 rets -> pc=A5, A4, A3, A2.
   - 5th ret with ret_reg_addr=0x777 -> pc=0x774, count=0.
5. Stall vs redirect:
   - stall=1 with link=1, br_taken=1 -> pc and ras_count unchanged.
   - stall=1 and redirect_valid=1, redirect_pc=0x1002 -> pc=0x1000.
6. Reset mid-operation: ras_count=3, ras_overflow=1, reset_n=0 with ret=1 -> pc=RESET_PC, ras_count=0, ras_overflow=0.
